// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM ROM arbiter: FSM states, client ids, defaults.
// Imported by the arbiter top and its per-client line cache.
package sdram_arb_pkg;

  localparam int AW_DEF      = 25;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    CL_DL,
    CL_A,
    CL_B
  } client_e;

  // SDRAM returns a 16-bit word; the byte address LSB picks the lane
  function automatic logic [7:0] lane_sel(
    input logic [15:0] word,
    input logic        odd
  );
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/rom_line_cache.sv
// One-entry address cache for a ROM read client.
// Invalidate wins over a fill arriving in the same cycle.
module rom_line_cache
  import sdram_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inv_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [7:0]    fill_byte_i,
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [7:0]    byte_o
);

  logic [AW-1:0] tag_q, tag_d;
  logic          vld_q, vld_d;
  logic [7:0]    byte_q, byte_d;

  always_comb begin
    tag_d  = tag_q;
    vld_d  = vld_q;
    byte_d = byte_q;
    if (fill_i) begin
      tag_d  = fill_addr_i;
      byte_d = fill_byte_i;
      vld_d  = 1'b1;
    end
    if (inv_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q  <= '0;
      vld_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      tag_q  <= tag_d;
      vld_q  <= vld_d;
      byte_q <= byte_d;
    end
  end

  assign hit_o  = vld_q && (tag_q == addr_i);
  assign byte_o = byte_q;

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares one SDRAM port between ROM download writes and two cached
// round-robin read clients; downloads always win.
module sdram_rom_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clock_48,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          a_rd,
  input  logic [AW-1:0] a_addr,
  output logic [7:0]    a_data,
  output logic          a_valid,
  input  logic          b_rd,
  input  logic [AW-1:0] b_addr,
  output logic [7:0]    b_data,
  output logic          b_valid,
  output logic [AW-1:0] sd_addr,
  output logic [15:0]   sd_din,
  output logic          sd_we,
  output logic          sd_rd,
  input  logic [15:0]   sd_dout,
  input  logic          sd_ready,
  output logic          timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  client_e       client_q, client_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dat_q, dat_d;
  logic          pend_v_q, pend_v_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_dat_q, pend_dat_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic          a_valid_q, a_valid_d;
  logic          b_valid_q, b_valid_d;
  logic [7:0]    a_data_q, a_data_d;
  logic [7:0]    b_data_q, b_data_d;
  logic          dla_q;

  logic       a_hit, b_hit;
  logic [7:0] a_cbyte, b_cbyte;
  logic [7:0] rd_byte;
  logic       done, tmo, inv;
  logic       fill_a, fill_b;
  logic       a_req, b_req;
  logic       a_miss, b_miss;
  logic       a_hit_go, b_hit_go;
  logic       wr_go, both, pick_a, pick_b;

  assign rd_byte = lane_sel(sd_dout, addr_q[0]);
  assign done    = (state_q == WAIT) && sd_ready;
  assign tmo     = (state_q == WAIT) && !sd_ready
                && (cnt_q == CW'(TIMEOUT - 1));
  assign fill_a  = done && (client_q == CL_A);
  assign fill_b  = done && (client_q == CL_B);
  assign inv     = (dl_wr && dl_active) || (dla_q && !dl_active);

  // a client is not re-served in the cycle its valid is showing
  assign a_req    = a_rd && !a_valid_q;
  assign b_req    = b_rd && !b_valid_q;
  assign a_miss   = a_req && !a_hit;
  assign b_miss   = b_req && !b_hit;
  assign a_hit_go = a_req && a_hit;
  assign b_hit_go = b_req && b_hit;
  assign wr_go    = pend_v_q || dl_wr;
  assign both     = a_miss && b_miss;
  assign pick_a   = a_miss && (!b_miss || !rr_q);
  assign pick_b   = b_miss && !pick_a;

  rom_line_cache #(.AW(AW)) u_cache_a (
    .clk_i       (clock_48),
    .rst_ni      (reset_n),
    .inv_i       (inv),
    .fill_i      (fill_a),
    .fill_addr_i (addr_q),
    .fill_byte_i (rd_byte),
    .addr_i      (a_addr),
    .hit_o       (a_hit),
    .byte_o      (a_cbyte)
  );

  rom_line_cache #(.AW(AW)) u_cache_b (
    .clk_i       (clock_48),
    .rst_ni      (reset_n),
    .inv_i       (inv),
    .fill_i      (fill_b),
    .fill_addr_i (addr_q),
    .fill_byte_i (rd_byte),
    .addr_i      (b_addr),
    .hit_o       (b_hit),
    .byte_o      (b_cbyte)
  );

  always_ff @(posedge clock_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_go || (!dl_active && (a_miss || b_miss))) begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sd_ready || tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sd_we = (state_q == ISSUE) && (client_q == CL_DL);
    sd_rd = (state_q == ISSUE) && (client_q != CL_DL);
  end

  always_comb begin
    client_d    = client_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    terr_d      = terr_q || tmo;
    a_valid_d   = 1'b0;
    b_valid_d   = 1'b0;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          client_d    = CL_DL;
          addr_d      = pend_addr_q;
          dat_d       = pend_dat_q;
          pend_v_d    = dl_wr;
          pend_addr_d = dl_wr ? dl_addr : pend_addr_q;
          pend_dat_d  = dl_wr ? dl_data : pend_dat_q;
        end else if (dl_wr) begin
          client_d = CL_DL;
          addr_d   = dl_addr;
          dat_d    = dl_data;
        end else if (!dl_active) begin
          if (a_hit_go) begin
            a_valid_d = 1'b1;
            a_data_d  = a_cbyte;
          end
          if (b_hit_go) begin
            b_valid_d = 1'b1;
            b_data_d  = b_cbyte;
          end
          if (pick_a) begin
            client_d = CL_A;
            addr_d   = a_addr;
          end else if (pick_b) begin
            client_d = CL_B;
            addr_d   = b_addr;
          end
          if (both) begin
            rr_d = !rr_q;
          end
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (fill_a) begin
          a_valid_d = 1'b1;
          a_data_d  = rd_byte;
        end
        if (fill_b) begin
          b_valid_d = 1'b1;
          b_data_d  = rd_byte;
        end
      end
      default: ;
    endcase
    // writes arriving mid-transaction wait in a one-deep slot
    if (state_q != IDLE && dl_wr) begin
      pend_v_d    = 1'b1;
      pend_addr_d = dl_addr;
      pend_dat_d  = dl_data;
    end
  end

  always_ff @(posedge clock_48 or negedge reset_n) begin
    if (!reset_n) begin
      client_q    <= CL_DL;
      addr_q      <= '0;
      dat_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      dla_q       <= 1'b0;
    end else begin
      client_q    <= client_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      dla_q       <= dl_active;
    end
  end

  assign sd_addr     = addr_q;
  assign sd_din      = {dat_q, dat_q};
  assign a_data      = a_data_q;
  assign a_valid     = a_valid_q;
  assign b_data      = b_data_q;
  assign b_valid     = b_valid_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Scoreboard bench for sdram_rom_arbiter: byte-memory reference model,
// behavioural SDRAM responder, directed cases plus a random phase.
module tb_sdram_rom_arbiter;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          a_rd = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [7:0]    a_data;
  logic          a_valid;
  logic          b_rd = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [7:0]    b_data;
  logic          b_valid;
  logic [AW-1:0] sd_addr;
  logic [15:0]   sd_din;
  logic          sd_we;
  logic          sd_rd;
  logic [15:0]   sd_dout = '0;
  logic          sd_ready = 1'b0;
  logic          timeout_err;

  always #5 clk = ~clk;

  sdram_rom_arbiter #(.AW(AW), .TIMEOUT(8)) dut (
    .clock_48    (clk),
    .reset_n     (rst_n),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .a_rd        (a_rd),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .a_valid     (a_valid),
    .b_rd        (b_rd),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .b_valid     (b_valid),
    .sd_addr     (sd_addr),
    .sd_din      (sd_din),
    .sd_we       (sd_we),
    .sd_rd       (sd_rd),
    .sd_dout     (sd_dout),
    .sd_ready    (sd_ready),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem[int];
  logic [7:0]  sd_mem[int];
  logic [7:0]  a_exp[$];
  logic [7:0]  b_exp[$];
  logic [40:0] wr_exp[$];
  logic [25:0] ops[$];
  int          n_rd = 0;
  int          fixed_lat = 0;
  bit          no_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] init_b(input int a);
    logic [31:0] t;
    t = a * 37;
    return t[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_get(input logic [AW-1:0] ad);
    int k = int'(ad);
    return ref_mem.exists(k) ? ref_mem[k] : init_b(k);
  endfunction

  function automatic logic [7:0] sd_get(input logic [AW-1:0] ad);
    int k = int'(ad);
    return sd_mem.exists(k) ? sd_mem[k] : init_b(k);
  endfunction

  function automatic logic [25:0] op_at(input int i);
    if (i < ops.size()) return ops[i];
    return '1;
  endfunction

  // SDRAM responder: pulses sd_ready a few cycles after an issue
  bit            busy = 1'b0;
  int            cnt = 0;
  bit            cap_wr = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [15:0]   cap_din = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sd_ready = 1'b0;
      busy = 1'b0;
    end else begin
      sd_ready = 1'b0;
      if (busy) begin
        chk("sd_hold", {sd_we, sd_rd, sd_addr, sd_din},
            {2'b00, cap_addr, cap_din});
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          if (!no_ready) begin
            logic [7:0] nz;
            nz = 8'($urandom);
            if (!cap_wr) begin
              sd_dout = cap_addr[0] ? {sd_get(cap_addr), nz}
                                    : {nz, sd_get(cap_addr)};
            end
            sd_ready = 1'b1;
          end
        end
      end else if (sd_we || sd_rd) begin
        chk("sd_one_hot", {sd_we, sd_rd} == 2'b11, 0);
        busy = 1'b1;
        cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        cap_wr = sd_we;
        cap_addr = sd_addr;
        cap_din = sd_din;
        ops.push_back({sd_we, sd_addr});
        if (sd_we) begin
          if (wr_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sd_write_unexpected: got addr %0h, required none",
                     sd_addr);
          end else begin
            chk("sd_write", {sd_addr, sd_din}, wr_exp.pop_front());
          end
          sd_mem[int'(sd_addr)] = sd_din[7:0];
        end else begin
          n_rd++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid) begin
        if (a_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_valid_unexpected: got data %0h, required none",
                   a_data);
        end else begin
          chk("a_data", a_data, a_exp.pop_front());
        end
      end
      if (b_valid) begin
        if (b_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_valid_unexpected: got data %0h, required none",
                   b_data);
        end else begin
          chk("b_data", b_data, b_exp.pop_front());
        end
      end
    end
  end

  task automatic do_read(input bit cl, input logic [AW-1:0] ad,
                         output int lat);
    if (!cl) begin
      a_exp.push_back(ref_get(ad));
      a_addr = ad;
      a_rd = 1'b1;
    end else begin
      b_exp.push_back(ref_get(ad));
      b_addr = ad;
      b_rd = 1'b1;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (cl ? b_valid : a_valid) break;
      if (lat >= 300) begin
        checks++;
        errors++;
        $display("FAIL read_wait: client %0d got no valid in %0d cycles",
                 cl, lat);
        break;
      end
    end
    if (!cl) a_rd = 1'b0;
    else b_rd = 1'b0;
  endtask

  task automatic dl_write(input logic [AW-1:0] ad, input logic [7:0] d);
    ref_mem[int'(ad)] = d;
    wr_exp.push_back({ad, d, d});
    dl_addr = ad;
    dl_data = d;
    dl_wr = 1'b1;
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  int            la, lb, n0, m, k, terr_at, r;
  logic [AW-1:0] aa, bb;

  initial begin
    sd_mem[0] = 8'hEF;
    sd_mem[1] = 8'hBE;
    ref_mem[0] = 8'hEF;
    ref_mem[1] = 8'hBE;
    repeat (3) @(negedge clk);
    chk("reset_outs", {a_data, a_valid, b_data, b_valid, sd_addr, sd_din,
                       sd_we, sd_rd, timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fixed_lat = 5;
    dl_active = 1'b1;
    @(negedge clk);
    dl_write(25'h123, 8'h5A);
    chk("dl_we_on", {sd_we, sd_rd, sd_addr, sd_din},
        {2'b10, 25'h123, 16'h5A5A});
    @(negedge clk);
    chk("dl_we_pulse", {sd_we, sd_rd, sd_addr}, {2'b00, 25'h123});
    repeat (8) @(negedge clk);
    dl_active = 1'b0;
    repeat (2) @(negedge clk);

    n0 = n_rd;
    do_read(0, 25'h1, la);
    chk("miss_lat", la, 7);
    chk("miss_sd_rd", n_rd - n0, 1);
    chk("a_data_BE", a_data, 8'hBE);
    @(negedge clk);
    n0 = n_rd;
    do_read(0, 25'h1, la);
    chk("hit_lat", la, 1);
    chk("hit_no_sd_rd", n_rd - n0, 0);
    fixed_lat = 0;
    @(negedge clk);

    m = ops.size();
    fork
      do_read(0, 25'h10, la);
      do_read(1, 25'h20, lb);
    join
    chk("rr1_first", op_at(m), {1'b0, 25'h10});
    chk("rr1_second", op_at(m + 1), {1'b0, 25'h20});
    @(negedge clk);
    m = ops.size();
    fork
      do_read(0, 25'h30, la);
      do_read(1, 25'h50, lb);
    join
    chk("rr2_first", op_at(m), {1'b0, 25'h50});
    chk("rr2_second", op_at(m + 1), {1'b0, 25'h30});
    @(negedge clk);

    fixed_lat = 6;
    m = ops.size();
    fork
      do_read(1, 25'h60, lb);
      begin
        repeat (2) @(negedge clk);
        fork
          do_read(0, 25'h70, la);
          begin
            @(negedge clk);
            dl_write(25'h300, 8'hC3);
          end
        join
      end
    join
    chk("prio_read_b", op_at(m), {1'b0, 25'h60});
    chk("prio_write", op_at(m + 1), {1'b1, 25'h300});
    chk("prio_read_a", op_at(m + 2), {1'b0, 25'h70});
    fixed_lat = 0;
    repeat (3) @(negedge clk);

    dl_active = 1'b1;
    @(negedge clk);
    n0 = n_rd;
    fork
      do_read(0, 25'h80, la);
      begin
        repeat (15) @(negedge clk);
        chk("no_rd_dl_active", n_rd - n0, 0);
        dl_active = 1'b0;
      end
    join
    chk("held_during_dl", la > 15, 1);
    @(negedge clk);

    do_read(0, 25'h40, la);
    @(negedge clk);
    do_read(0, 25'h40, la);
    chk("hit_40_lat", la, 1);
    dl_active = 1'b1;
    @(negedge clk);
    dl_write(25'h40, 8'h77);
    repeat (10) @(negedge clk);
    dl_active = 1'b0;
    @(negedge clk);
    n0 = n_rd;
    do_read(0, 25'h40, la);
    chk("inv_wr_sd_rd", n_rd - n0, 1);
    chk("inv_new_byte", a_data, 8'h77);
    @(negedge clk);

    do_read(1, 25'h44, lb);
    @(negedge clk);
    do_read(1, 25'h44, lb);
    chk("hit_44_lat", lb, 1);
    dl_active = 1'b1;
    repeat (3) @(negedge clk);
    dl_active = 1'b0;
    @(negedge clk);
    n0 = n_rd;
    do_read(1, 25'h44, lb);
    chk("inv_fall_sd_rd", n_rd - n0, 1);
    @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      aa = 25'h200 + 25'($urandom_range(0, 15));
      bb = 25'h200 + 25'($urandom_range(0, 15));
      if (r < 4) begin
        do_read(0, aa, la);
      end else if (r < 7) begin
        do_read(1, bb, lb);
      end else if (r < 9) begin
        fork
          do_read(0, aa, la);
          do_read(1, bb, lb);
        join
      end else begin
        dl_active = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          dl_write(25'h200 + 25'($urandom_range(0, 15)), 8'($urandom));
          repeat (9) @(negedge clk);
        end
        dl_active = 1'b0;
        @(negedge clk);
      end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);

    chk("no_err_before", timeout_err, 0);
    no_ready = 1'b1;
    a_addr = 25'h99;
    a_rd = 1'b1;
    k = 0;
    while (!sd_rd && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_first_issue", sd_rd, 1);
    k = 0;
    terr_at = -1;
    do begin
      @(negedge clk);
      k++;
      if (timeout_err && terr_at < 0) terr_at = k;
    end while (!sd_rd && k < 30);
    chk("to_reissue_gap", k, 10);
    chk("to_err_cycle", terr_at, 9);
    rst_n = 1'b0;
    a_rd = 1'b0;
    #1;
    chk("rst_async", {sd_we, sd_rd, timeout_err, sd_addr, sd_din,
                      a_data, b_data, a_valid, b_valid}, 0);
    no_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n0 = n_rd;
    do_read(0, 25'h1, la);
    chk("post_rst_miss", n_rd - n0, 1);
    repeat (3) @(negedge clk);

    chk("queues_empty", {a_exp.size() == 0, b_exp.size() == 0,
                         wr_exp.size() == 0}, 3'b111);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_rom_arbiter.md
Name: sdram_rom_arbiter

Overview:
- Shares the single SDRAM controller port between the ROM download stream and two ROM read clients: main CPU and sound CPU / graphics fetch.
- Sits between data_io / game core and the sdram block, in the clock_48 domain.
- Download writes have absolute priority; the two read clients are served round-robin.
- Each read client has a one-entry address cache, so repeated reads of the same address do not touch SDRAM.

Parameters:
- AW, 25, SDRAM byte-address width.
- TIMEOUT, 64, clock_48 cycles to wait for sd_ready before aborting a transaction.

Ports:
- clock_48  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  one-cycle write strobe.
- dl_addr  in  AW  download byte address.
- dl_data  in  8  download byte.
- a_rd  in  1  client A read request, level, held until a_valid.
- a_addr  in  AW  client A byte address, stable while a_rd.
- a_data  out  8  client A read data.
- a_valid  out  1  one-cycle pulse, a_data valid.
- b_rd  in  1  client B read request (same rules as a_rd).
- b_addr  in  AW  client B byte address.
- b_data  out  8  client B read data.
- b_valid  out  1  one-cycle pulse.
- sd_addr  out  AW  to sdram addr.
- sd_din  out  16  to sdram din, = {byte, byte}.
- sd_we  out  1  to sdram we.
- sd_rd  out  1  to sdram rd.
- sd_dout  in  16  from sdram dout.
- sd_ready  in  1  one-cycle pulse, operation complete.
- timeout_err  out  1  sticky, set on any timeout.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; round-robin pointer = A.
  - Both cache tags invalid; timeout counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE, priority order:
  1. dl_wr=1: latch dl_addr/dl_data, go ISSUE(write).
  2. dl_active=1: serve nothing else; read requests wait.
  3. Cache check for each client with rd=1: if the tag is valid and equals addr, pulse valid with the cached byte in the next cycle. No SDRAM access. Both clients may hit in the same cycle.
  4. Otherwise pick a missing requester. Use the round-robin pointer when both miss; the pointer then flips to the other client. Latch its addr, go ISSUE(read).
- ISSUE:
  - sd_addr driven from the latch; exactly one of sd_we/sd_rd high for exactly one cycle; then WAIT.
  - sd_addr and sd_din are held stable from ISSUE through WAIT.
- WAIT:
  - Counter increments each cycle.
  - sd_ready=1, write: return to IDLE.
  - sd_ready=1, read:
    - Byte lane = sd_dout[7:0] if addr[0]=0, else sd_dout[15:8].
    - Register it into the client's data output and its cache. Tag = addr, valid=1.
    - Pulse the client's valid the next cycle; go IDLE.
  - Counter reaches TIMEOUT-1 without sd_ready: set timeout_err, go IDLE, no valid pulse. The read client re-arbitrates if it still requests.
- Read latency, cache hit: valid 1 cycle after rd sampled. Miss: ISSUE + SDRAM latency + 1.
- a_data/b_data hold their last value until the next completed read for that client.
- Any dl_wr while dl_active invalidates both cache tags.
- Falling edge of dl_active also invalidates both tags.
- dl_wr during ISSUE/WAIT is captured in a one-deep pending register and served at the next IDLE, ahead of reads.
- A second dl_wr while the pending register is full overwrites it. Not a legal data_io pattern, but deterministic.
- A client dropping rd mid-transaction: the transaction completes and the cache fills; the valid pulse is still emitted.
- Reset asserted mid-transaction: immediate return to reset state. sd_rd/sd_we deassert asynchronously.
- timeout_err clears only on reset.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT}.
  - client id enum {CL_DL, CL_A, CL_B}.
  - AW default constant.
- One natural sub-module: rom_line_cache, instantiated once per client.
  - Holds tag, valid, byte.
  - Provides hit compare, fill, invalidate.

Test Plan:
- Download write: dl_active=1, dl_wr pulse addr 0x0123 data 0x5A -> sd_we one cycle, sd_addr=0x0123, sd_din=0x5A5A. Model ready after 5 cycles -> state IDLE.
- Read miss, then hit:
  - a_rd addr 0x0001, model returns 0xBEEF -> a_data=0xBE, a_valid one pulse.
  - Repeat same addr -> a_valid 1 cycle later, no sd_rd.
- Contention: a_rd 0x10 and b_rd 0x20 same cycle, both miss -> A served first, then B. Next simultaneous misses -> B first.
- Download priority: a_rd pending while dl_wr arrives mid-WAIT -> write issued before the next read. No read issued while dl_active=1.
- Cache invalidation: hit cached for addr 0x40; download rewrites memory; dl_active falls -> next a_rd 0x40 issues sd_rd and returns the new byte.
- Timeout: model never pulses ready (TIMEOUT=8) -> back in IDLE after 8 WAIT cycles, timeout_err=1, no a_valid. Mid-WAIT reset_n=0 -> all outputs 0 immediately.
